// File: rtl/tlc_sensor_cond.sv
// tlc_sensor_cond: detector conditioner for the two-street traffic-light controller.
// Each channel synchronises its raw loop-detector level and debounces it. The
// resulting demand stays latched until that street has been served. Channel 0 is
// street A (main) and channel 1 is street B (side).
// Build option: define SENSOR_STUCK_DET_EN to enable stuck-high detection.
// When it is enabled, a stuck detector forces demand for that street.
// When it is not defined, stuck_a and stuck_b are tied to 0.

module tlc_sensor_cond #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned STUCK_CYC    = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_a,
  input  logic raw_b,
  input  logic Ga,
  input  logic Gb,
  output logic Sa,
  output logic Sb,
  output logic stuck_a,
  output logic stuck_b
);

  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned STUCK_W = $clog2(STUCK_CYC + 1);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_COUNT  = 1'b1
  } deb_state_t;

  // Reject parameter values the datapath cannot represent.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("tlc_sensor_cond: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYC < 1) begin : g_bad_deb
    $error("tlc_sensor_cond: DEBOUNCE_CYC must be >= 1");
  end
  if (STUCK_CYC < 1) begin : g_bad_stuck
    $error("tlc_sensor_cond: STUCK_CYC must be >= 1");
  end

  logic [1:0] raw_v;
  logic [1:0] grn_v;

  assign raw_v = {raw_b, raw_a};
  assign grn_v = {Gb, Ga};

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    deb_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   filt_q, filt_d;
    logic                   lat_q, lat_d;
    logic                   stuck_int;
    logic                   s_q;

    // Synchroniser chain for the asynchronous detector level.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], raw_v[ch]};
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Debounce FSM, filtered level and demand latch registers.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= ST_STABLE;
        cnt_q   <= '0;
        filt_q  <= 1'b0;
        lat_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        filt_q  <= filt_d;
        lat_q   <= lat_d;
      end
    end

    // Next-state logic: count consecutive differing samples before accepting a change.
    // The latch is set on the rising edge of filt, and set wins over clear.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      filt_d  = filt_q;
      lat_d   = lat_q;
      case (state_q)
        ST_STABLE: begin
          if (sync != filt_q) begin
            if (DEBOUNCE_CYC == 1) begin
              filt_d = sync;
              cnt_d  = '0;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = ST_COUNT;
            end
          end
        end
        ST_COUNT: begin
          if (sync == filt_q) begin
            cnt_d   = '0;
            state_d = ST_STABLE;
          end else if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
            filt_d  = sync;
            cnt_d   = '0;
            state_d = ST_STABLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = ST_STABLE;
        end
      endcase
      if (filt_d && !filt_q)         lat_d = 1'b1;
      else if (grn_v[ch] && !filt_q) lat_d = 1'b0;
    end

`ifdef SENSOR_STUCK_DET_EN
    logic [STUCK_W-1:0] scnt_q, scnt_d;
    logic               stk_q;

    // Saturating count of consecutive filtered-high cycles.
    always_comb begin
      scnt_d = '0;
      if (filt_q) begin
        if (scnt_q == STUCK_W'(STUCK_CYC)) scnt_d = scnt_q;
        else                               scnt_d = scnt_q + STUCK_W'(1);
      end
    end

    // Stuck flag follows the next count. It drops one cycle after filt falls.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        scnt_q <= '0;
        stk_q  <= 1'b0;
      end else begin
        scnt_q <= scnt_d;
        stk_q  <= (scnt_d == STUCK_W'(STUCK_CYC));
      end
    end

    assign stuck_int = stk_q;
`else
    assign stuck_int = 1'b0;
`endif

    // Registered demand output. A stuck detector keeps its street being served.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) s_q <= 1'b0;
      else        s_q <= filt_q | lat_q | stuck_int;
    end
  end

  assign Sa      = g_ch[0].s_q;
  assign Sb      = g_ch[1].s_q;
  assign stuck_a = g_ch[0].stuck_int;
  assign stuck_b = g_ch[1].stuck_int;

endmodule

// File: tb/tb_tlc_sensor_cond.sv
// tb_tlc_sensor_cond: directed scoreboard bench for tlc_sensor_cond (default parameters).
// Expected stuck flags track SENSOR_STUCK_DET_EN the same way the design does.

module tb_tlc_sensor_cond;

`ifdef SENSOR_STUCK_DET_EN
  localparam logic STUCK_ON = 1'b1;
`else
  localparam logic STUCK_ON = 1'b0;
`endif

  typedef struct packed {
    logic sa;
    logic sb;
    logic sta;
    logic stb;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic raw_a, raw_b, Ga, Gb;
  logic Sa, Sb, stuck_a, stuck_b;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  logic st;

  tlc_sensor_cond #(
    .SYNC_STAGES (2),
    .DEBOUNCE_CYC(4),
    .STUCK_CYC   (64)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .raw_a  (raw_a),
    .raw_b  (raw_b),
    .Ga     (Ga),
    .Gb     (Gb),
    .Sa     (Sa),
    .Sb     (Sb),
    .stuck_a(stuck_a),
    .stuck_b(stuck_b)
  );

  always #5 clk = ~clk;

  // Take the next expectation from the queue and compare it with the outputs now.
  task automatic check_now(input string tag);
    exp_t e;
    exp_t got;
    got = {Sa, Sb, stuck_a, stuck_b};
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $error("FAIL %s: scoreboard empty, got=%b", tag, got);
    end else begin
      e = sb_q.pop_front();
      assert (got === e) else begin
        bad++;
        $error("FAIL %s: got {Sa,Sb,stuck_a,stuck_b}=%b want=%b at %0t", tag, got, e, $time);
      end
    end
  endtask

  // For n clock edges: queue the expectation, advance one edge, then check #1 after it.
  task automatic run(input string tag, input int n,
                     input logic e_sa, input logic e_sb,
                     input logic e_sta, input logic e_stb);
    for (int i = 0; i < n; i++) begin
      sb_q.push_back({e_sa, e_sb, e_sta, e_stb});
      @(posedge clk);
      #1;
      check_now(tag);
    end
  endtask

  initial begin
    st    = STUCK_ON;
    reset = 1'b0;
    raw_a = 1'b1;
    raw_b = 1'b1;
    Ga    = 1'b0;
    Gb    = 1'b0;

    // Reset held with both detectors active, then release: demand 7 edges later.
    run("reset_hold", 10, 0, 0, 0, 0);
    reset = 1'b1;
    run("rel_latency", 6, 0, 0, 0, 0);
    run("rel_rise", 1, 1, 1, 0, 0);
    raw_a = 1'b0;
    raw_b = 1'b0;
    Ga    = 1'b1;
    Gb    = 1'b1;
    run("both_clear_hold", 7, 1, 1, 0, 0);
    run("both_cleared", 3, 0, 0, 0, 0);
    Ga = 1'b0;
    Gb = 1'b0;

    // A 3-cycle glitch is rejected. A 4-cycle pulse is accepted and latched.
    raw_b = 1'b1;
    run("glitch3_in", 3, 0, 0, 0, 0);
    raw_b = 1'b0;
    run("glitch3_rej", 20, 0, 0, 0, 0);
    raw_b = 1'b1;
    run("pulse4_in", 4, 0, 0, 0, 0);
    raw_b = 1'b0;
    run("pulse4_wait", 2, 0, 0, 0, 0);
    run("pulse4_rise", 1, 0, 1, 0, 0);
    run("pulse4_latched", 20, 0, 1, 0, 0);
    Gb = 1'b1;
    run("pulse4_clr_lat", 1, 0, 1, 0, 0);
    run("pulse4_cleared", 5, 0, 0, 0, 0);
    Gb = 1'b0;

    // Latch holds a 6-cycle pulse for 100 cycles until Gb, then clears 2 edges later.
    raw_b = 1'b1;
    run("latch_in", 6, 0, 0, 0, 0);
    raw_b = 1'b0;
    run("latch_rise", 1, 0, 1, 0, 0);
    run("latch_hold", 100, 0, 1, 0, 0);
    Gb = 1'b1;
    run("latch_clr1", 1, 0, 1, 0, 0);
    run("latch_clr2", 1, 0, 0, 0, 0);
    Gb = 1'b0;
    run("latch_idle", 3, 0, 0, 0, 0);

    // Gb asserted on the edge where filt_b rises: set wins and the latch survives.
    raw_b = 1'b1;
    run("coll_in", 5, 0, 0, 0, 0);
    Gb = 1'b1;
    run("coll_edge", 1, 0, 0, 0, 0);
    Gb = 1'b0;
    run("coll_rise", 1, 0, 1, 0, 0);
    raw_b = 1'b0;
    run("coll_held", 15, 0, 1, 0, 0);
    Gb = 1'b1;
    run("coll_clr1", 1, 0, 1, 0, 0);
    run("coll_clr2", 3, 0, 0, 0, 0);
    Gb = 1'b0;

    // Stuck detector on A: flag after 64 filtered-high cycles when enabled.
    raw_a = 1'b1;
    run("stuck_lat", 6, 0, 0, 0, 0);
    run("stuck_pre", 63, 1, 0, 0, 0);
    run("stuck_set", 1, 1, 0, st, 0);
    Ga = 1'b1;
    run("stuck_green", 10, 1, 0, st, 0);
    raw_a = 1'b0;
    run("stuck_drop", 6, 1, 0, st, 0);
    run("stuck_clr", 1, 1, 0, 0, 0);
    run("stuck_idle", 3, 0, 0, 0, 0);
    Ga = 1'b0;

    // Asynchronous reset pulse between edges drops latched demand at once.
    raw_a = 1'b1;
    run("mid_in", 6, 0, 0, 0, 0);
    raw_a = 1'b0;
    run("mid_rise", 1, 1, 0, 0, 0);
    run("mid_latched", 10, 1, 0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    sb_q.push_back(4'b0000);
    check_now("mid_async_rst");
    reset = 1'b1;
    run("mid_no_relatch", 20, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
